// File: rtl/if_fetch_if.sv
// ============================================================================
// if_fetch_if -- memory, redirect and IF/ID handshake bundle for if_fetch
// Revision: 1.0
// ============================================================================
`default_nettype none

interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i,
    input  jump_i,
    input  jump_addr_i,
    output valid_o,
    input  ready_i,
    output pc_o,
    output inst_o
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i,
    output jump_i,
    output jump_addr_i,
    input  valid_o,
    output ready_i,
    input  pc_o,
    input  inst_o
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// if_fetch -- byte-serial instruction fetch assembling 32-bit words for IF/ID
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] pc_q;
  logic [23:0] buf_q;
  logic [23:0] buf_d;
  logic        valid_q;
  logic [31:0] pc_out_q;
  logic [31:0] inst_q;
  logic        fetching;
  logic        jump_lsb_unused;

  // Requests are masked combinationally so reset silences the bus immediately.
  assign fetching   = (state_q == ST_FETCH) && !rst;

  assign bus.mem_req_o  = fetching;
  assign bus.mem_addr_o = fetching ? (pc_q + {30'd0, cnt_q}) : 32'd0;
  assign bus.valid_o    = valid_q;
  assign bus.pc_o       = pc_out_q;
  assign bus.inst_o     = inst_q;

  // Targets are word aligned; the low address bits are dropped.
  assign jump_lsb_unused = ^bus.jump_addr_i[1:0];

  always_comb begin
    buf_d = buf_q;
    case (cnt_q)
      2'd0:    buf_d[7:0]   = bus.mem_data_i;
      2'd1:    buf_d[15:8]  = bus.mem_data_i;
      2'd2:    buf_d[23:16] = bus.mem_data_i;
      default: buf_d        = buf_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      cnt_q    <= 2'd0;
      pc_q     <= RESET_PC;
      buf_q    <= 24'd0;
      valid_q  <= 1'b0;
      pc_out_q <= 32'd0;
      inst_q   <= 32'd0;
    end else if (bus.jump_i) begin
      // Redirect wins over any ack this cycle; a concurrent handshake still completes.
      state_q <= ST_FETCH;
      cnt_q   <= 2'd0;
      pc_q    <= {bus.jump_addr_i[31:2], 2'b00};
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.mem_ack_i) begin
            if (cnt_q == 2'd3) begin
              inst_q   <= {bus.mem_data_i, buf_q};
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_q + 32'd4;
              cnt_q    <= 2'd0;
              state_q  <= ST_HOLD;
            end else begin
              buf_q <= buf_d;
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            state_q <= ST_FETCH;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// tb_if_fetch -- directed scenarios plus randomized run against a word-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] h;
    case (a)
      32'd0:   h = 8'h13;
      32'd1:   h = 8'h05;
      32'd2:   h = 8'h10;
      32'd3:   h = 8'h00;
      default: h = (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
    return h;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  assign bus.mem_data_i = mem_byte(bus.mem_addr_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves rst high after two reset edges; caller's next tick starts cycle 1.
  task automatic apply_reset();
    tick();
    rst = 1'b1; bus.mem_ack_i = 1'b0; bus.jump_i = 1'b0;
    bus.jump_addr_i = 32'd0; bus.ready_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1; bus.mem_ack_i = 1'b1; bus.jump_i = 1'b0;
    bus.jump_addr_i = 32'd0; bus.ready_i = 1'b0;
    sample();
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: req=%b addr=%h, required req=0 addr=0", bus.mem_req_o, bus.mem_addr_o);
    end
    tick();
    sample();
    checks++;
    if (bus.valid_o !== 1'b0 || bus.pc_o !== 32'd0 || bus.inst_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: valid=%b pc=%h inst=%h, required 0/0/0", bus.valid_o, bus.pc_o, bus.inst_o);
    end
    tick();
    rst = 1'b0; bus.mem_ack_i = 1'b0;
    sample();
    checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h, required req=1 addr=0", bus.mem_req_o, bus.mem_addr_o);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      rst = 1'b0; bus.mem_ack_i = 1'b1;
      sample();
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'(c - 1) || bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_addr c%0d: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                 c, bus.mem_req_o, bus.mem_addr_o, bus.valid_o, 32'(c - 1));
      end
    end
    tick();
    bus.mem_ack_i = 1'b0; bus.ready_i = 1'b0;
    sample();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.inst_o !== 32'h0010_0513 || bus.pc_o !== 32'd0 || bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_emit: valid=%b inst=%h pc=%h req=%b, required 1/00100513/0/0",
               bus.valid_o, bus.inst_o, bus.pc_o, bus.mem_req_o);
    end
  endtask

  task automatic test_hold_stall();
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.ready_i = 1'b0; bus.mem_ack_i = 1'b1;
      sample();
      checks++;
      if (bus.mem_req_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.inst_o !== 32'h0010_0513 || bus.pc_o !== 32'd0) begin
        errors++;
        $display("FAIL hold_stable c%0d: req=%b valid=%b inst=%h pc=%h, required 0/1/00100513/0",
                 c, bus.mem_req_o, bus.valid_o, bus.inst_o, bus.pc_o);
      end
    end
    tick();
    bus.ready_i = 1'b1; bus.mem_ack_i = 1'b0;
    sample();
    checks++;
    if (bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_handshake: valid=%b, required 1", bus.valid_o);
    end
    tick();
    bus.ready_i = 1'b0;
    sample();
    checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h4 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_next_req: req=%b addr=%h valid=%b, required 1/00000004/0",
               bus.mem_req_o, bus.mem_addr_o, bus.valid_o);
    end
  endtask

  task automatic test_alt_ack();
    apply_reset();
    for (int c = 1; c <= 8; c++) begin
      tick();
      rst = 1'b0; bus.mem_ack_i = (c % 2 == 0);
      sample();
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'((c - 1) / 2) || bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL alt_addr c%0d: req=%b addr=%h valid=%b, required 1/%h/0",
                 c, bus.mem_req_o, bus.mem_addr_o, bus.valid_o, 32'((c - 1) / 2));
      end
    end
    tick();
    bus.mem_ack_i = 1'b0;
    sample();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.inst_o !== 32'h0010_0513 || bus.pc_o !== 32'd0) begin
      errors++;
      $display("FAIL alt_emit: valid=%b inst=%h pc=%h, required 1/00100513/0", bus.valid_o, bus.inst_o, bus.pc_o);
    end
  endtask

  task automatic test_jump_mid();
    apply_reset();
    for (int c = 1; c <= 3; c++) begin
      tick();
      rst = 1'b0; bus.mem_ack_i = 1'b1;
      bus.jump_i = (c == 3); bus.jump_addr_i = 32'h100;
      sample();
      checks++;
      if (bus.mem_addr_o !== 32'(c - 1)) begin
        errors++;
        $display("FAIL jmid_pre c%0d: addr=%h, required %h", c, bus.mem_addr_o, 32'(c - 1));
      end
    end
    for (int c = 4; c <= 7; c++) begin
      tick();
      bus.jump_i = 1'b0; bus.mem_ack_i = 1'b1;
      sample();
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h100 + 32'(c - 4) || bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL jmid_target c%0d: req=%b addr=%h valid=%b, required 1/%h/0",
                 c, bus.mem_req_o, bus.mem_addr_o, bus.valid_o, 32'h100 + 32'(c - 4));
      end
    end
    tick();
    bus.mem_ack_i = 1'b0;
    sample();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h100 || bus.inst_o !== mem_word(32'h100)) begin
      errors++;
      $display("FAIL jmid_emit: valid=%b pc=%h inst=%h, required 1/00000100/%h",
               bus.valid_o, bus.pc_o, bus.inst_o, mem_word(32'h100));
    end
  endtask

  task automatic test_jump_last_byte();
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      rst = 1'b0; bus.mem_ack_i = 1'b1;
      bus.jump_i = (c == 4); bus.jump_addr_i = 32'h200;
    end
    for (int c = 5; c <= 8; c++) begin
      tick();
      bus.jump_i = 1'b0; bus.mem_ack_i = 1'b1;
      sample();
      checks++;
      if (bus.valid_o !== 1'b0 || bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h200 + 32'(c - 5)) begin
        errors++;
        $display("FAIL jlast_restart c%0d: valid=%b req=%b addr=%h, required 0/1/%h",
                 c, bus.valid_o, bus.mem_req_o, bus.mem_addr_o, 32'h200 + 32'(c - 5));
      end
    end
    tick();
    bus.mem_ack_i = 1'b0;
    sample();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h200 || bus.inst_o !== mem_word(32'h200)) begin
      errors++;
      $display("FAIL jlast_emit: valid=%b pc=%h inst=%h, required 1/00000200/%h",
               bus.valid_o, bus.pc_o, bus.inst_o, mem_word(32'h200));
    end
  endtask

  // Starts in HOLD: jump coincides with an accepted handshake.
  task automatic test_wrap();
    tick();
    bus.jump_i = 1'b1; bus.jump_addr_i = 32'hFFFF_FFFC; bus.ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      bus.jump_i = 1'b0; bus.ready_i = 1'b0; bus.mem_ack_i = 1'b1;
      sample();
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'hFFFF_FFFC + 32'(c) || bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL wrap_addr c%0d: req=%b addr=%h valid=%b, required 1/%h/0",
                 c, bus.mem_req_o, bus.mem_addr_o, bus.valid_o, 32'hFFFF_FFFC + 32'(c));
      end
    end
    tick();
    bus.mem_ack_i = 1'b0; bus.ready_i = 1'b1;
    sample();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'hFFFF_FFFC || bus.inst_o !== mem_word(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap_emit: valid=%b pc=%h inst=%h, required 1/fffffffc/%h",
               bus.valid_o, bus.pc_o, bus.inst_o, mem_word(32'hFFFF_FFFC));
    end
    tick();
    bus.ready_i = 1'b0;
    sample();
    checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'd0) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h, required 1/00000000", bus.mem_req_o, bus.mem_addr_o);
    end
  endtask

  // Word-level model: next word address, bytes delivered so far, word on display.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] held_pc;
    int          got;
    bit          presenting;
    int          accepted;
    apply_reset();
    exp_pc = 32'd0; got = 0; presenting = 1'b0; held_pc = 32'd0; accepted = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst             = (i > 0) && ($urandom_range(0, 199) == 0);
      bus.mem_ack_i   = ($urandom_range(0, 9) < 7);
      bus.ready_i     = ($urandom_range(0, 9) < 5);
      bus.jump_i      = ($urandom_range(0, 29) == 0);
      bus.jump_addr_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      sample();
      checks++;
      if (rst) begin
        if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'd0) begin
          errors++;
          $display("FAIL rnd_rst cyc%0d: req=%b addr=%h, required 0/0", i, bus.mem_req_o, bus.mem_addr_o);
        end
      end else if (presenting) begin
        if (bus.mem_req_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.pc_o !== held_pc || bus.inst_o !== mem_word(held_pc)) begin
          errors++;
          $display("FAIL rnd_hold cyc%0d: req=%b valid=%b pc=%h inst=%h, required 0/1/%h/%h",
                   i, bus.mem_req_o, bus.valid_o, bus.pc_o, bus.inst_o, held_pc, mem_word(held_pc));
        end
      end else begin
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== exp_pc + 32'(got) || bus.valid_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd_fetch cyc%0d: req=%b addr=%h valid=%b, required 1/%h/0",
                   i, bus.mem_req_o, bus.mem_addr_o, bus.valid_o, exp_pc + 32'(got));
        end
      end
      if (rst) begin
        exp_pc = 32'd0; got = 0; presenting = 1'b0;
      end else if (bus.jump_i) begin
        if (presenting && bus.ready_i) accepted++;
        exp_pc = bus.jump_addr_i & 32'hFFFF_FFFC; got = 0; presenting = 1'b0;
      end else if (presenting) begin
        if (bus.ready_i) begin
          presenting = 1'b0; accepted++;
        end
      end else if (bus.mem_ack_i) begin
        got++;
        if (got == 4) begin
          held_pc = exp_pc; exp_pc = exp_pc + 32'd4; got = 0; presenting = 1'b1;
        end
      end
    end
    checks++;
    if (accepted < 50) begin
      errors++;
      $display("FAIL rnd_progress: accepted=%0d, required >= 50", accepted);
    end
    rst = 1'b0; bus.jump_i = 1'b0; bus.mem_ack_i = 1'b0; bus.ready_i = 1'b0;
  endtask

  initial begin
    bus.mem_ack_i = 1'b0; bus.jump_i = 1'b0; bus.jump_addr_i = 32'd0; bus.ready_i = 1'b0;
    test_reset();
    test_basic();
    test_hold_stall();
    test_alt_ack();
    test_jump_mid();
    test_jump_last_byte();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_req_o  output  1  byte read request to instruction memory.
REQ-005 SHALL have port mem_addr_o  output  32  byte address of the current request.
REQ-006 SHALL have port mem_ack_i  input  1  memory accepted the request; mem_data_i is valid in the same cycle.
REQ-007 SHALL have port mem_data_i  input  8  read byte.
REQ-008 SHALL have port jump_i  input  1  redirect request from decode.
REQ-009 SHALL have port jump_addr_i  input  32  redirect target.
REQ-010 SHALL have port valid_o  output  1  instruction/PC pair available to the IF/ID register.
REQ-011 SHALL have port ready_i  input  1  downstream accepts the pair when valid_o && ready_i.
REQ-012 SHALL have port pc_o  output  32  address of inst_o.
REQ-013 SHALL have port inst_o  output  32  assembled instruction, little-endian.

Function
REQ-014 SHALL implement two states: FETCH (byte counter cnt 0..3) and HOLD (instruction presented).
REQ-015 In FETCH, the block SHALL drive mem_req_o=1 and mem_addr_o=pc_r+cnt, mod 2^32.
REQ-016 In FETCH, on mem_ack_i the block SHALL store mem_data_i in byte lane cnt of the buffer and increment cnt; without ack, mem_addr_o SHALL hold.
REQ-017 On ack with cnt==3, the block SHALL register inst_o={mem_data_i, buf[23:0]}, pc_o=pc_r, valid_o=1, pc_r=pc_r+4 (wraps 0xFFFFFFFC->0), and enter HOLD.
REQ-018 Latency: with ack every cycle, valid_o SHALL rise in the 5th cycle after entering FETCH; steady-state throughput SHALL be 1 instruction per 5 cycles.
REQ-019 In HOLD, mem_req_o SHALL be 0, and inst_o, pc_o and valid_o SHALL stay stable while ready_i=0.
REQ-020 In HOLD with ready_i=1, the block SHALL clear valid_o and enter FETCH with cnt=0 on the next edge.
REQ-021 With jump_i=1 in any state, on the next edge the block SHALL set pc_r={jump_addr_i[31:2],2'b00}, cnt=0, valid_o=0 and state=FETCH.
REQ-022 With jump_i=1, any ack in that cycle SHALL be discarded, partial bytes SHALL be discarded and no instruction SHALL be emitted.
REQ-023 Priority SHALL be rst > jump_i > final-byte ack > ready handshake.
REQ-024 If jump_i and valid_o&&ready_i occur together, the transfer SHALL count as accepted downstream, and the next fetch SHALL be at the jump target.
REQ-025 The block SHALL ignore mem_ack_i whenever mem_req_o=0.

Reset
REQ-026 With rst=1 at an edge, the block SHALL set: state=FETCH, cnt=0, pc_r=RESET_PC, valid_o=0, pc_o=0, inst_o=0, buffer=0.
REQ-027 mem_req_o SHALL be 0 in every cycle rst is high, and mem_addr_o SHALL be 0 then.
REQ-028 Reset mid-fetch or in HOLD SHALL abandon the in-progress instruction with no emission.
REQ-029 The first request after reset SHALL be to RESET_PC in the cycle after rst falls.

Verification
REQ-030 Reset, ack every cycle, bytes 13 05 10 00 at 0..3 -> addr 0,1,2,3 on cycles 1-4; cycle 5 valid_o=1, inst_o=0x00100513, pc_o=0.
REQ-031 ready_i=0 for 3 cycles in HOLD -> mem_req_o=0 and outputs stable; ready_i=1 -> next request addr 0x4.
REQ-032 Ack on alternate cycles -> each address held until acked; same inst_o, valid_o on cycle 9.
REQ-033 jump_i=1, jump_addr_i=0x100 after 2 bytes acked -> next request addr 0x100; emitted pc_o=0x100 with target bytes only.
REQ-034 jump_i coincident with 4th-byte ack -> valid_o stays 0; fetch restarts at target.
REQ-035 Jump to 0xFFFFFFFC -> addresses FC,FD,FE,FF; after handshake next request addr 0x0.
